// File: rtl/beat_pkg.sv
// Shared types and defaults for the beat generator.
// The four beat states and the default machine-cycle counter width.
package beat_pkg;

  typedef enum logic [1:0] {B_IDLE, B_W1, B_W2, B_W3} beat_state_t;

  localparam int CYC_W_DEF = 8;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector with a configurable reset value for the history flop.
// Resetting the history to 1 stops a level that is held through reset from looking like an edge.
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/beat_gen.sv
// Beat sequencer: one-hot W1/W2/W3 strobes per machine cycle, with short/long/stop/single-step control.
// A start edge only counts while the sequencer is idle.
module beat_gen
  import beat_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             dp,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic             cyc_end
);

  beat_state_t state;
  logic        stop_pend;
  logic        start;

  edge_det #(.RST_VAL(1'b1)) u_qd_edge (
    .clk  (t3),
    .rst  (clr),
    .d    (qd),
    .rise (start)
  );

  always_comb begin
    cyc_end = 1'b0;
    case (state)
      B_W1:    cyc_end = short;
      B_W2:    cyc_end = !long;
      B_W3:    cyc_end = 1'b1;
      default: cyc_end = 1'b0;
    endcase
  end

  // A stop seen in a non-final beat is remembered until the cycle finishes.
  always_ff @(posedge t3) begin
    if (clr) begin
      state     <= B_IDLE;
      stop_pend <= 1'b0;
      cyc_cnt   <= '0;
    end else if (cyc_end) begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
      if (stop_pend || stop || dp) begin
        state     <= B_IDLE;
        stop_pend <= 1'b0;
      end else begin
        state <= B_W1;
      end
    end else begin
      case (state)
        B_IDLE:  if (start) state <= B_W1;
        B_W1:    state <= B_W2;
        B_W2:    state <= B_W3;
        default: state <= B_IDLE;
      endcase
      if (stop && state != B_IDLE) stop_pend <= 1'b1;
    end
  end

  assign w1      = (state == B_W1);
  assign w2      = (state == B_W2);
  assign w3      = (state == B_W3);
  assign running = (state != B_IDLE);

endmodule

// File: tb/tb_beat_gen.sv
// Scoreboard bench for beat_gen: a beat-number reference model queues expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_beat_gen;

  localparam int CW = 8;

  logic          t3 = 1'b0;
  logic          clr, qd, dp, short, long, stop;
  logic          w1, w2, w3, running, cyc_end;
  logic [CW-1:0] cyc_cnt;

  beat_gen #(.CYC_W(CW)) dut (
    .t3      (t3),
    .clr     (clr),
    .qd      (qd),
    .dp      (dp),
    .short   (short),
    .long    (long),
    .stop    (stop),
    .w1      (w1),
    .w2      (w2),
    .w3      (w3),
    .running (running),
    .cyc_cnt (cyc_cnt),
    .cyc_end (cyc_end)
  );

  always #5 t3 = ~t3;

  typedef struct packed {
    logic c;
    logic q;
    logic d;
    logic s;
    logic l;
    logic p;
  } stim_t;

  stim_t         cur;
  int            m_beat;
  int            m_cnt;
  bit            m_pend;
  bit            m_qdq;
  logic [CW+4:0] expq[$];
  int            checks = 0;
  int            passed = 0;

  // Beat number 0 means idle; the cycle ends at beat 1 on short, beat 2 without long, always at beat 3.
  function automatic bit modelEnd(input stim_t s);
    return (m_beat == 1 && s.s) || (m_beat == 2 && !s.l) || (m_beat == 3);
  endfunction

  function automatic void modelStep(input stim_t s);
    bit fin;
    if (s.c) begin
      m_beat = 0;
      m_cnt  = 0;
      m_pend = 1'b0;
      m_qdq  = 1'b1;
    end else begin
      fin = modelEnd(s);
      if (m_beat == 0) begin
        if (s.q && !m_qdq) m_beat = 1;
      end else if (fin) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_pend || s.p || s.d) begin
          m_beat = 0;
          m_pend = 1'b0;
        end else begin
          m_beat = 1;
        end
      end else begin
        if (s.p) m_pend = 1'b1;
        m_beat = m_beat + 1;
      end
      m_qdq = s.q;
    end
  endfunction

  function automatic logic [CW+4:0] expected();
    logic [CW-1:0] c;
    c = CW'(m_cnt);
    return {m_beat == 1, m_beat == 2, m_beat == 3, m_beat != 0, modelEnd(cur), c};
  endfunction

  task automatic applyStimulus(input bit c, input bit q, input bit d,
                               input bit s, input bit l, input bit p);
    @(posedge t3);
    #2;
    modelStep(cur);
    cur   = '{c, q, d, s, l, p};
    clr   = c;
    qd    = q;
    dp    = d;
    short = s;
    long  = l;
    stop  = p;
    expq.push_back(expected());
  endtask

  task automatic checkOutput(input logic [CW+4:0] exp);
    logic [CW+4:0] act;
    act = {w1, w2, w3, running, cyc_end, cyc_cnt};
    checks++;
    if (act === exp) passed++;
    else
      $display("[TB] FAIL beats t=%0t: got w1w2w3=%b run=%b end=%b cnt=%0d, want w1w2w3=%b run=%b end=%b cnt=%0d",
               $time, act[CW+4:CW+2], act[CW+1], act[CW], act[CW-1:0],
               exp[CW+4:CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
  endtask

  initial begin
    forever begin
      @(negedge t3);
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    clr = 1'b1; qd = 1'b1; dp = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
    cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    m_beat = 0; m_cnt = 0; m_pend = 1'b0; m_qdq = 1'b1;

    // Reset with button held, hold it, then a real press.
    applyStimulus(1, 1, 0, 0, 0, 0);
    repeat (5) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Short, default, long cycles back to back.
    applyStimulus(0, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Stop in W1 of a long cycle, then resume with a new press.
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Short and long together in W1, halting via single-step.
    applyStimulus(0, 1, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);

    // Single-step: three presses, with an extra press inside each cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
    end

    // Reset during W2 with a stop pending, then a cycle that must not halt.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Counter wrap: continuous single-beat cycles.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    repeat (262) applyStimulus(0, 1, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                    ($urandom_range(7) == 0), ($urandom_range(2) == 0),
                    ($urandom_range(1) == 0), ($urandom_range(7) == 0));
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge t3);
    #1;
    if (expq.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/beat_gen.md
# beat_gen

Beat (timing-pulse) generator feeding the hardwired controller. Each machine cycle it drives one-hot beat strobes `w1`/`w2`/`w3` on the `t3` clock. It shortens or lengthens the cycle according to the controller's `short`/`long` requests. It halts on the controller's `stop` or in single-step mode, and restarts on a start-button pulse.

## Interface
Parameters:
- `CYC_W`, 8, width of the machine-cycle counter.

Ports:
- `t3`  in  1  clock; all state updates on its rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `qd`  in  1  start button, already debounced and synchronous to `t3`; a rising edge starts the sequencer.
- `dp`  in  1  single-step mode; when 1, halt after every machine cycle.
- `short`  in  1  from controller; end the machine cycle after W1.
- `long`  in  1  from controller; extend the machine cycle to W3.
- `stop`  in  1  from controller; halt at the end of the current machine cycle.
- `w1`  out  1  beat 1 strobe.
- `w2`  out  1  beat 2 strobe.
- `w3`  out  1  beat 3 strobe.
- `running`  out  1  1 while any beat is active.
- `cyc_cnt`  out  CYC_W  completed machine cycles, modulo 2^CYC_W.
- `cyc_end`  out  1  1 during the last beat of a machine cycle.

## Operation
- States: IDLE, W1, W2, W3.
- Outputs: `w1`/`w2`/`w3` are 1 exactly in their state; all are 0 in IDLE. `running` = state != IDLE.
- Start detect: `qd_q` is the registered `qd`; start = `qd & ~qd_q`.
- IDLE: on start, go to W1. Otherwise stay.
- W1: if `short`, end the cycle. Otherwise go to W2.
- W2: if `long`, go to W3. Otherwise end the cycle.
- W3: always end the cycle.
- End of cycle: increment `cyc_cnt`, wrapping from max to 0. Then:
  - if `stop_pend | stop | dp`, go to IDLE and clear `stop_pend`;
  - otherwise go to W1.
- `stop_pend`:
  - sets when `stop` is sampled 1 in any non-final beat;
  - is not cleared by `stop` deasserting later in the cycle;
  - clears on entry to IDLE.
- `cyc_end`: combinational from state and inputs. It is 1 in W1 when `short`, in W2 when `!long`, and always in W3.
- Priority: `short` and `long` both 1 in W1 → `short` wins. `long` is ignored in W1 and W3. `short` is ignored in W2 and W3.
- A start pulse while `running` is ignored; it is neither queued nor allowed to restart the cycle.
- Start and a pending halt in the same edge: the halt to IDLE takes effect. The start is lost because the start edge occurred while `running`.

## Timing
- Reset values: state = IDLE; `w1`=`w2`=`w3`=0; `running`=0; `cyc_cnt`=0; `stop_pend`=0; `qd_q`=1.
  - Because `qd_q` resets to 1, a button held through reset does not start the sequencer.
- `clr` overrides everything. If asserted mid-beat, all outputs reach reset values after that edge; the partial cycle is not counted.
- Start latency: `qd` goes 0→1, is sampled at edge N, and `w1`=1 from edge N until edge N+1.
- Each beat lasts exactly one `t3` period.
- `short`, `long` and `stop` are sampled at the rising edge that ends the current beat. The controller may derive them combinationally from `w*` and `ir` within that beat.
- Machine cycle length: 1 beat with `short`, 2 beats default, 3 beats with `long`.
- Back-to-back cycles have no gap: W1 follows the final beat on the next edge.
- `cyc_cnt` updates on the same edge that leaves the final beat.

## Structure
- Package `beat_pkg`:
  - `typedef enum logic [1:0] {B_IDLE, B_W1, B_W2, B_W3} beat_state_t`;
  - localparam `CYC_W_DEF = 8`.
- One sub-module is natural: `edge_det`, a rising-edge detector with a configurable reset value for its history flop. Instantiate it for `qd` with reset value 1.
- Everything else lives in `beat_gen`: the state register, next-state logic, `stop_pend`, and the counter.

## Test plan
- Reset and start:
  - stimulus: `clr`=1 for 2 cycles with `qd`=1, then release; hold `qd`=1 for 5 cycles; then drop `qd` to 0 and raise it to 1 again;
  - required: no beats while `qd` is held after reset; `w1`=1 exactly one cycle after the second rising edge of `qd`.
- Beat patterns, `dp`=0:
  - stimulus: `short`=1 in W1 for cycle 1; default in cycle 2; `long`=1 in W2 for cycle 3;
  - required: beat sequence W1 | W1 W2 | W1 W2 W3 with no gaps; `cyc_cnt` goes 0→1→2→3.
- Single step:
  - stimulus: `dp`=1, 2-beat cycles, 3 `qd` pulses;
  - required: exactly 3 cycles of W1 W2; IDLE between them; `cyc_cnt`=3; `qd` pulses during a cycle have no effect.
- Stop:
  - stimulus: `stop`=1 for one cycle during W1 of a long cycle, 0 afterwards;
  - required: W2 and W3 still complete, then IDLE; a new `qd` edge resumes at W1.
- Priority and wrap:
  - stimulus: `short`=`long`=1 in W1; separately, run with `CYC_W`=8 from `cyc_cnt`=255;
  - required: the cycle ends after W1; the counter wraps 255→0.
- Reset mid-operation:
  - stimulus: `clr`=1 during W2;
  - required: next cycle shows IDLE, all strobes 0, `cyc_cnt`=0, `stop_pend` cleared.
